// File: rtl/icache_refill_unit_pkg.sv
// Shared constants and types for the icache line-refill engine.
package icache_refill_unit_pkg;

    localparam int unsigned ICACHE_WORDS_PER_LINE = 4;
    localparam int unsigned ICACHE_BEAT_IDX_W     = 2;
    localparam int unsigned ICACHE_OFFSET_BITS    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } type_refill_state_e;

endpackage : icache_refill_unit_pkg

// File: rtl/icache_refill_unit_if.sv
// Word-beat req/ack bus between the refill engine (master) and instruction memory (slave).
interface icache_refill_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (output mem_req_o, output mem_addr_o, input  mem_ack_i, input  mem_rdata_i);
    modport slave  (input  mem_req_o, input  mem_addr_o, output mem_ack_i, output mem_rdata_i);
endinterface : icache_refill_unit_if

// File: rtl/icache_refill_unit.sv
// Fetches one cache line as four word beats and assembles it into a slot-indexed line buffer.
// Optional: ICACHE_REFILL_CRITICAL_WORD_FIRST_EN starts the burst at the missed word and wraps.
module icache_refill_unit
    import icache_refill_unit_pkg::*;
#(
    parameter int unsigned ICACHE_ADDR_WIDTH = 32,
    parameter int unsigned ICACHE_LINE_WIDTH = 128,
    parameter int unsigned IMEM_BUS_WIDTH    = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [ICACHE_ADDR_WIDTH-1:0] icache2imem_addr_i,
    input  logic                         refill_req_i,
    input  logic                         refill_kill_i,
    output logic                         refill_busy_o,
    output logic                         refill_done_o,
    output logic [ICACHE_LINE_WIDTH-1:0] imem2icache_data_o,
    icache_refill_unit_if.master         mem
);

    localparam int unsigned LINE_ADDR_W = ICACHE_ADDR_WIDTH - ICACHE_OFFSET_BITS;
    localparam int unsigned WORD_OFF_W  = ICACHE_OFFSET_BITS - ICACHE_BEAT_IDX_W;

    type_refill_state_e             state_q, state_d;
    logic [LINE_ADDR_W-1:0]         line_q, line_d;
    logic [ICACHE_BEAT_IDX_W-1:0]   off_q, off_d;
    logic [ICACHE_BEAT_IDX_W-1:0]   cnt_q, cnt_d;
    logic                           kill_q, kill_d;
    logic [ICACHE_BEAT_IDX_W-1:0]   beat_idx;
    logic [ICACHE_WORDS_PER_LINE-1:0] slot_we;
    logic [IMEM_BUS_WIDTH-1:0]      slot_q [ICACHE_WORDS_PER_LINE];
    logic                           unused_addr_bits;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    assign beat_idx         = cnt_q + off_q;
    assign unused_addr_bits = ^icache2imem_addr_i[WORD_OFF_W-1:0];
`else
    assign beat_idx         = cnt_q;
    assign unused_addr_bits = ^{icache2imem_addr_i[WORD_OFF_W-1:0], off_q};
`endif

    // Control state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            line_q  <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
        end
    end

    // A kill lets the outstanding beat finish, then drops back to IDLE at its ack.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        kill_d  = kill_q;
        slot_we = '0;
        unique case (state_q)
            IDLE: begin
                if (refill_req_i) begin
                    state_d = REQ;
                    line_d  = icache2imem_addr_i[ICACHE_ADDR_WIDTH-1:ICACHE_OFFSET_BITS];
                    off_d   = icache2imem_addr_i[ICACHE_OFFSET_BITS-1:WORD_OFF_W];
                    cnt_d   = '0;
                    kill_d  = 1'b0;
                end
            end
            REQ: begin
                if (refill_kill_i) begin
                    kill_d = 1'b1;
                end
                if (mem.mem_ack_i) begin
                    slot_we[beat_idx] = 1'b1;
                    cnt_d             = cnt_q + ICACHE_BEAT_IDX_W'(1);
                    if (kill_q || refill_kill_i) begin
                        state_d = IDLE;
                    end else if (cnt_q == ICACHE_BEAT_IDX_W'(ICACHE_WORDS_PER_LINE - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Line buffer: one register per word slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(ICACHE_WORDS_PER_LINE); k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(ICACHE_WORDS_PER_LINE); k++) begin
                if (slot_we[k]) begin
                    slot_q[k] <= mem.mem_rdata_i;
                end
            end
        end
    end

    for (genvar g = 0; g < int'(ICACHE_WORDS_PER_LINE); g++) begin : g_line
        assign imem2icache_data_o[g*IMEM_BUS_WIDTH +: IMEM_BUS_WIDTH] = slot_q[g];
    end

    // Outputs decode state and registers only; address is zeroed outside REQ.
    assign mem.mem_req_o  = (state_q == REQ);
    assign mem.mem_addr_o = (state_q == REQ) ? {line_q, beat_idx, {WORD_OFF_W{1'b0}}}
                                             : '0;
    assign refill_busy_o  = (state_q == REQ) || (state_q == DONE);
    assign refill_done_o  = (state_q == DONE);

endmodule : icache_refill_unit

// File: tb/tb_icache_refill_unit.sv
// Directed, table-driven bench for icache_refill_unit (honours ICACHE_REFILL_CRITICAL_WORD_FIRST_EN).
module tb_icache_refill_unit;

    typedef struct {
        logic         req;
        logic         kill;
        logic         ack;
        logic [31:0]  addr_in;
        logic [31:0]  rdata;
        logic         exp_req;
        logic         exp_busy;
        logic         exp_done;
        logic [31:0]  exp_addr;
        logic         chk_line;
        logic [127:0] exp_line;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr_in = '0;
    logic         req = 1'b0;
    logic         kill = 1'b0;
    logic         busy;
    logic         done;
    logic [127:0] line;

    int unsigned total = 0;
    int unsigned bad   = 0;
    vec_t        vecs[$];

    icache_refill_unit_if bus ();

    icache_refill_unit dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .icache2imem_addr_i (addr_in),
        .refill_req_i       (req),
        .refill_kill_i      (kill),
        .refill_busy_o      (busy),
        .refill_done_o      (done),
        .imem2icache_data_o (line),
        .mem                (bus.master)
    );

    always #5 clk = ~clk;

    function automatic int unsigned order(int unsigned off, int unsigned k);
        int unsigned start;
        start = 0;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
        start = off;
`endif
        return (start + k) % 4;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic row(logic r, logic kl, logic a, logic [31:0] ain, logic [31:0] rd,
                       logic er, logic eb, logic ed, logic [31:0] ea,
                       logic cl, logic [127:0] el);
        vec_t v;
        v.req = r; v.kill = kl; v.ack = a; v.addr_in = ain; v.rdata = rd;
        v.exp_req = er; v.exp_busy = eb; v.exp_done = ed; v.exp_addr = ea;
        v.chk_line = cl; v.exp_line = el;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(string tag, logic er, logic eb, logic ed, logic [31:0] ea);
        chk({tag, ".mem_req"}, 128'(bus.mem_req_o), 128'(er));
        chk({tag, ".busy"},    128'(busy),          128'(eb));
        chk({tag, ".done"},    128'(done),          128'(ed));
        chk({tag, ".addr"},    128'(bus.mem_addr_o), 128'(ea));
    endtask

    initial begin
        int unsigned o;
        logic [127:0] l1, l2, l4a, l4b, l5;
        l1  = {32'h44, 32'h33, 32'h22, 32'h11};
        l2  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        l4a = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        l4b = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        l5  = {32'h63, 32'h62, 32'h61, 32'h60};

        // Zero-wait refill at 0x1008.
        row(1, 0, 0, 32'h1008, 0, 0, 0, 0, 0, 0, '0);
        for (int k = 0; k < 4; k++) begin
            o = order(2, k);
            row(0, 0, 1, 32'h1008, 32'h11 * (o + 1), 1, 1, 0, 32'h1000 + 4 * o, 0, '0);
        end
        row(0, 0, 0, 32'h1008, 0, 0, 1, 1, 0, 1, l1);
        row(0, 0, 0, 32'h1008, 0, 0, 0, 0, 0, 1, l1);

        // Beat 1 waits three cycles; done in cycle 8.
        row(1, 0, 0, 32'h1000, 0, 0, 0, 0, 0, 0, '0);
        row(0, 0, 1, 32'h1000, 32'hA0, 1, 1, 0, 32'h1000, 0, '0);
        for (int k = 0; k < 3; k++) row(0, 0, 0, 32'h1000, 0, 1, 1, 0, 32'h1004, 0, '0);
        row(0, 0, 1, 32'h1000, 32'hA1, 1, 1, 0, 32'h1004, 0, '0);
        row(0, 0, 1, 32'h1000, 32'hA2, 1, 1, 0, 32'h1008, 0, '0);
        row(0, 0, 1, 32'h1000, 32'hA3, 1, 1, 0, 32'h100C, 0, '0);
        row(0, 0, 0, 32'h1000, 0, 0, 1, 1, 0, 1, l2);
        row(0, 0, 0, 32'h1000, 0, 0, 0, 0, 0, 1, l2);

        // Kill during beat 2 wait: beat completes, then IDLE, no done, kill in IDLE ignored.
        row(1, 0, 0, 32'h3000, 0, 0, 0, 0, 0, 0, '0);
        row(0, 0, 1, 32'h3000, 32'hB0, 1, 1, 0, 32'h3000, 0, '0);
        row(0, 0, 1, 32'h3000, 32'hB1, 1, 1, 0, 32'h3004, 0, '0);
        row(0, 1, 0, 32'h3000, 0, 1, 1, 0, 32'h3008, 0, '0);
        row(0, 0, 0, 32'h3000, 0, 1, 1, 0, 32'h3008, 0, '0);
        row(0, 0, 1, 32'h3000, 32'hB2, 1, 1, 0, 32'h3008, 0, '0);
        row(0, 1, 0, 32'h3000, 0, 0, 0, 0, 0, 0, '0);
        row(0, 0, 0, 32'h3000, 0, 0, 0, 0, 0, 0, '0);

        // Request held high through DONE: second refill accepted only from IDLE.
        row(1, 0, 0, 32'h4004, 0, 0, 0, 0, 0, 0, '0);
        for (int k = 0; k < 4; k++) begin
            o = order(1, k);
            row(1, 0, 1, 32'h4004, 32'hC0 + o, 1, 1, 0, 32'h4000 + 4 * o, 0, '0);
        end
        row(1, 0, 0, 32'h4004, 0, 0, 1, 1, 0, 1, l4a);
        row(1, 0, 0, 32'h4004, 0, 0, 0, 0, 0, 1, l4a);
        for (int k = 0; k < 4; k++) begin
            o = order(1, k);
            row(0, 0, 1, 32'h4004, 32'hD0 + o, 1, 1, 0, 32'h4000 + 4 * o, 0, '0);
        end
        row(0, 0, 0, 32'h4004, 0, 0, 1, 1, 0, 1, l4b);
        row(0, 0, 0, 32'h4004, 0, 0, 0, 0, 0, 1, l4b);

        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;

        // Reset state.
        @(negedge clk);
        check_outputs("reset", 0, 0, 0, 0);
        chk("reset.line", line, '0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_busy,
                          vecs[i].exp_done, vecs[i].exp_addr);
            if (vecs[i].chk_line) chk($sformatf("vec%0d.line", i), line, vecs[i].exp_line);
            req             = vecs[i].req;
            kill            = vecs[i].kill;
            addr_in         = vecs[i].addr_in;
            bus.mem_ack_i   = vecs[i].ack;
            bus.mem_rdata_i = vecs[i].rdata;
        end

        // Reset asserted mid-beat-1 clears outputs and line before the next edge.
        @(negedge clk);
        req = 1'b1; addr_in = 32'h5008; bus.mem_ack_i = 1'b0;
        @(negedge clk);
        req = 1'b0; bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h55;
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
        check_outputs("rst.beat1", 1, 1, 0, 32'h5000 + 4 * order(2, 1));
        #2 rst = 1'b1;
        #1;
        chk("rst.async.mem_req", 128'(bus.mem_req_o), 128'(0));
        chk("rst.async.busy", 128'(busy), 128'(0));
        chk("rst.async.line", line, '0);
        @(negedge clk);
        rst = 1'b0;
        req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req = 1'b0;
            o = order(2, k);
            check_outputs($sformatf("restart.beat%0d", k), 1, 1, 0, 32'h5000 + 4 * o);
            bus.mem_ack_i = 1'b1;
            bus.mem_rdata_i = 32'h60 + o;
        end
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
        check_outputs("restart.done", 0, 1, 1, 0);
        chk("restart.line", line, l5);
        @(negedge clk);
        check_outputs("restart.idle", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_icache_refill_unit
